// File: rtl/rx_ip_analy.sv
// rx_ip_analy: IPv4 receive parser; validates the header, strips it and options,
// and trims Ethernet padding to Total Length before handing the payload to rx_udp_analy.
module rx_ip_analy #(
  parameter int DATA_W = 32,
  parameter int IP_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IP_W-1:0]   cfg_ip_local,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic [1:0]        din_mty,
  input  logic              din_err,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic [1:0]        dout_mty,
  output logic              dout_err,
  output logic              flag_ip_err,
  output logic              flag_sum_err,
  output logic              flag_proto_err
);
  typedef enum logic [1:0] {IDLE, HEAD, DATA, DISCARD} state_t;
  state_t            r_state, w_state_nx;
  logic [3:0]        r_hcnt, r_ihl;
  logic [15:0]       r_tlen, r_rem;
  logic [20:0]       r_sum;
  logic              r_ver_err, r_proto_err, r_dst_err, r_err_acc, r_first;
  logic              w_sop, w_last, w_dst_err, w_ip_err, w_sum_err, w_any_err, w_rem_last;
  logic [20:0]       w_sum;
  logic [16:0]       w_fold1, w_fold2;
  logic [15:0]       w_hlen, w_pl;
  logic [DATA_W-1:0] w_dout;
  logic              w_vld, w_dsop, w_deop, w_derr, w_fip, w_fsum, w_fproto;
  logic [1:0]        w_dmty;
  assign w_sop      = din_vld & din_sop;
  assign w_hlen     = {10'd0, r_ihl, 2'b00};
  assign w_pl       = r_tlen - w_hlen;
  assign w_rem_last = r_rem <= 16'd4;
  // 15 words of two halfwords can exceed 20 bits, so the running sum is 21 bits wide
  assign w_sum      = r_sum + 21'(din[31:16]) + 21'(din[15:0]);
  assign w_fold1    = 17'(w_sum[15:0]) + 17'(w_sum[20:16]);
  assign w_fold2    = 17'(w_fold1[15:0]) + 17'(w_fold1[16]);
  assign w_sum_err  = w_fold2[15:0] != 16'hffff;
  // a header claiming IHL<5 is still read to word 4 so the decision always sees the dst IP
  assign w_last     = r_hcnt == ((r_ihl < 4'd5) ? 4'd4 : r_ihl - 4'd1);
  assign w_dst_err  = (r_hcnt == 4'd4) ? (din != cfg_ip_local) : r_dst_err;
  assign w_ip_err   = r_ver_err | (r_ihl < 4'd5) | (r_tlen < w_hlen) | w_dst_err;
  assign w_any_err  = w_ip_err | w_sum_err | r_proto_err;
  always_comb begin
    w_state_nx = r_state;
    w_vld      = 1'b0;
    w_dout     = '0;
    w_dsop     = 1'b0;
    w_deop     = 1'b0;
    w_dmty     = 2'd0;
    w_derr     = 1'b0;
    w_fip      = 1'b0;
    w_fsum     = 1'b0;
    w_fproto   = 1'b0;
    if (w_sop) begin
      w_state_nx = din_eop ? IDLE : HEAD;
      w_fip      = din_eop;
      w_vld      = r_state == DATA;
      w_dsop     = (r_state == DATA) & r_first;
      w_deop     = r_state == DATA;
      w_derr     = r_state == DATA;
    end else if (din_vld) begin
      case (r_state)
        HEAD: begin
          w_fip      = w_last ? w_ip_err : din_eop;
          w_fsum     = w_last & w_sum_err;
          w_fproto   = w_last & r_proto_err;
          w_state_nx = din_eop ? IDLE : !w_last ? HEAD : (w_any_err || w_pl == 16'd0) ? DISCARD : DATA;
        end
        DATA: begin
          w_vld      = 1'b1;
          w_dout     = din;
          w_dsop     = r_first;
          w_deop     = din_eop | w_rem_last;
          w_dmty     = w_rem_last ? 2'd0 - r_rem[1:0] : din_eop ? din_mty : 2'd0;
          w_derr     = w_rem_last ? r_err_acc | din_err : din_eop;
          w_state_nx = din_eop ? IDLE : w_rem_last ? DISCARD : DATA;
        end
        DISCARD: w_state_nx = din_eop ? IDLE : DISCARD;
        default: w_state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt      <= '0;
      r_ihl       <= '0;
      r_tlen      <= '0;
      r_rem       <= '0;
      r_sum       <= '0;
      r_ver_err   <= 1'b0;
      r_proto_err <= 1'b0;
      r_dst_err   <= 1'b0;
      r_err_acc   <= 1'b0;
      r_first     <= 1'b0;
    end else if (w_sop) begin
      r_hcnt      <= 4'd1;
      r_ihl       <= din[27:24];
      r_tlen      <= din[15:0];
      r_sum       <= 21'(din[31:16]) + 21'(din[15:0]);
      r_ver_err   <= din[31:28] != 4'd4;
      r_proto_err <= 1'b0;
      r_dst_err   <= 1'b0;
      r_err_acc   <= din_err;
      r_first     <= 1'b1;
    end else if (din_vld) begin
      r_err_acc <= r_err_acc | din_err;
      if (r_state == HEAD) begin
        r_hcnt      <= r_hcnt + 4'd1;
        r_sum       <= w_sum;
        r_dst_err   <= w_dst_err;
        r_rem       <= w_pl;
        r_proto_err <= r_proto_err | ((r_hcnt == 4'd1) & (din[13] | (|din[12:0])))
                                   | ((r_hcnt == 4'd2) & (din[23:16] != 8'h11));
      end
      if (r_state == DATA) begin
        r_rem   <= r_rem - 16'd4;
        r_first <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout           <= '0;
      dout_vld       <= 1'b0;
      dout_sop       <= 1'b0;
      dout_eop       <= 1'b0;
      dout_mty       <= 2'd0;
      dout_err       <= 1'b0;
      flag_ip_err    <= 1'b0;
      flag_sum_err   <= 1'b0;
      flag_proto_err <= 1'b0;
    end else begin
      dout           <= w_dout;
      dout_vld       <= w_vld;
      dout_sop       <= w_dsop;
      dout_eop       <= w_deop;
      dout_mty       <= w_dmty;
      dout_err       <= w_derr;
      flag_ip_err    <= w_fip;
      flag_sum_err   <= w_fsum;
      flag_proto_err <= w_fproto;
    end
  end
endmodule
